// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types, defaults and flag helpers for cmp_result_tracker
package cmp_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int RUN_W_DEF    = 4;
    localparam int LOCK_LEN_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_GT = 2'd0,
        CLS_EQ = 2'd1,
        CLS_LT = 2'd2
    } cls_t;

    // Priority decode gt > eq > lt; all-zero falls through to lt.
    function automatic cls_t decode_cls(input logic gt, input logic eq, input logic lt);
        cls_t c;
        if (gt)
            c = CLS_GT;
        else if (eq)
            c = CLS_EQ;
        else
            c = CLS_LT;
        if (lt) begin
        end
        return c;
    endfunction

    // True only for 100, 010, 001.
    function automatic logic is_onehot(input logic gt, input logic eq, input logic lt);
        return (gt ^ eq ^ lt) & ~(gt & eq & lt);
    endfunction

endpackage

// File: rtl/cmp_result_tracker_if.sv
// rtl/cmp_result_tracker_if.sv - sample/result bundle between comparator, tracker and consumer
//   clear, in_valid, in_gt, in_eq, in_lt : towards the tracker
//   out_*, *_cnt, eq_run, locked, lock_lost, err : from the tracker
interface cmp_result_tracker_if #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
);
    logic             clear;
    logic             in_valid;
    logic             in_gt;
    logic             in_eq;
    logic             in_lt;
    logic             out_valid;
    logic             out_gt;
    logic             out_eq;
    logic             out_lt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [RUN_W-1:0] eq_run;
    logic             locked;
    logic             lock_lost;
    logic             err;

    modport master (
        output clear, in_valid, in_gt, in_eq, in_lt,
        input  out_valid, out_gt, out_eq, out_lt,
        input  gt_cnt, eq_cnt, lt_cnt, eq_run, locked, lock_lost, err
    );

    modport slave (
        input  clear, in_valid, in_gt, in_eq, in_lt,
        output out_valid, out_gt, out_eq, out_lt,
        output gt_cnt, eq_cnt, lt_cnt, eq_run, locked, lock_lost, err
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
//   clk, rst (sync, active high), clr (sync soft clear), inc, q
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - registers comparator flags, counts classes, tracks equal-run lock
//   clk, rst (sync, active high), bus (cmp_result_tracker_if.slave)
//   Optional macro CMP_ONEHOT_CHECK_EN: non-one-hot samples go to sticky ERROR with err=1.
module cmp_result_tracker
    import cmp_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_LEN = LOCK_LEN_DEF,
    parameter int RUN_W    = RUN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    cmp_result_tracker_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    cls_t             cls;
    logic             accept;
    logic             legal;
    logic             take;
    logic             is_eq;
    logic [RUN_W-1:0] run_inc;

    // clear wins over a simultaneous sample; ERROR swallows everything.
    assign accept = bus.in_valid && !bus.clear && (state != ERROR);
    assign cls    = decode_cls(bus.in_gt, bus.in_eq, bus.in_lt);

`ifdef CMP_ONEHOT_CHECK_EN
    logic bad;
    assign legal = is_onehot(bus.in_gt, bus.in_eq, bus.in_lt);
    assign bad   = accept && !legal;
`else
    assign legal = 1'b1;
`endif

    assign take    = accept && legal;
    assign is_eq   = (cls == CLS_EQ);
    // Run value the eq_run counter will show after this eq sample.
    assign run_inc = (bus.eq_run == '1) ? bus.eq_run : bus.eq_run + RUN_W'(1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, TRACK: begin
                if (take)
                    state_nx = (is_eq && (run_inc >= RUN_W'(LOCK_LEN))) ? LOCKED : TRACK;
            end
            LOCKED: begin
                if (take && !is_eq)
                    state_nx = TRACK;
            end
`ifdef CMP_ONEHOT_CHECK_EN
            ERROR:   state_nx = ERROR;
`else
            ERROR:   state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
`ifdef CMP_ONEHOT_CHECK_EN
        if (bad)
            state_nx = ERROR;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            bus.out_valid <= 1'b0;
            bus.out_gt    <= 1'b0;
            bus.out_eq    <= 1'b0;
            bus.out_lt    <= 1'b0;
            bus.lock_lost <= 1'b0;
        end else begin
            bus.out_valid <= take;
            if (take) begin
                bus.out_gt <= (cls == CLS_GT);
                bus.out_eq <= (cls == CLS_EQ);
                bus.out_lt <= (cls == CLS_LT);
            end
            // Illegal samples never reach take, so an ERROR exit cannot pulse this.
            bus.lock_lost <= take && !is_eq && (state == LOCKED);
        end
    end

`ifdef CMP_ONEHOT_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst || bus.clear)
            err_q <= 1'b0;
        else if (bad)
            err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.locked = (state == LOCKED);

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (take && (cls == CLS_GT)),
        .q   (bus.gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (take && (cls == CLS_EQ)),
        .q   (bus.eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (take && (cls == CLS_LT)),
        .q   (bus.lt_cnt)
    );

    // Any accepted gt/lt breaks the equal run.
    sat_counter #(.W(RUN_W)) u_eq_run (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear || (take && !is_eq)),
        .inc (take && is_eq),
        .q   (bus.eq_run)
    );

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb/tb_cmp_result_tracker.sv - directed self-checking bench for cmp_result_tracker
module tb_cmp_result_tracker;
    import cmp_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cmp_result_tracker_if #(.CNT_W(8), .RUN_W(4)) bus ();

    cmp_result_tracker #(.CNT_W(8), .LOCK_LEN(4), .RUN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample, let one edge pass, land 1 time unit after it.
    task automatic step(input logic v, input logic g, input logic e, input logic l, input logic c);
        bus.in_valid = v;
        bus.in_gt    = g;
        bus.in_eq    = e;
        bus.in_lt    = l;
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_gt"},    32'(bus.out_gt),    0);
        check({tag, "_out_eq"},    32'(bus.out_eq),    0);
        check({tag, "_out_lt"},    32'(bus.out_lt),    0);
        check({tag, "_gt_cnt"},    32'(bus.gt_cnt),    0);
        check({tag, "_eq_cnt"},    32'(bus.eq_cnt),    0);
        check({tag, "_lt_cnt"},    32'(bus.lt_cnt),    0);
        check({tag, "_eq_run"},    32'(bus.eq_run),    0);
        check({tag, "_locked"},    32'(bus.locked),    0);
        check({tag, "_lock_lost"}, 32'(bus.lock_lost), 0);
        check({tag, "_err"},       32'(bus.err),       0);
        check({tag, "_state"},     32'(dut.state),     32'(IDLE));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_gt = 1'b0;
        bus.in_eq = 1'b0;
        bus.in_lt = 1'b0;

        // Reset held two cycles, then five idle cycles.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check_zero("reset");

        // Lock entry after four equal samples.
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 1, 0, 0);
            check($sformatf("entry_run%0d", i), 32'(bus.eq_run), i);
            check($sformatf("entry_valid%0d", i), 32'(bus.out_valid), 1);
            check($sformatf("entry_locked%0d", i), 32'(bus.locked), (i == 4) ? 1 : 0);
        end
        check("entry_eq_cnt", 32'(bus.eq_cnt), 4);
        check("entry_state", 32'(dut.state), 32'(LOCKED));

        // Lock loss on gt.
        step(1, 1, 0, 0, 0);
        check("loss_locked", 32'(bus.locked), 0);
        check("loss_pulse", 32'(bus.lock_lost), 1);
        check("loss_run", 32'(bus.eq_run), 0);
        check("loss_gt_cnt", 32'(bus.gt_cnt), 1);
        check("loss_out_gt", 32'(bus.out_gt), 1);
        check("loss_state", 32'(dut.state), 32'(TRACK));
        step(0, 0, 0, 0, 0);
        check("loss_pulse_end", 32'(bus.lock_lost), 0);
        check("idle_valid", 32'(bus.out_valid), 0);
        check("idle_hold_gt", 32'(bus.out_gt), 1);
        check("idle_hold_gt_cnt", 32'(bus.gt_cnt), 1);

        // Saturation of lt_cnt over 300 samples.
        for (int i = 1; i <= 300; i++) begin
            step(1, 0, 0, 1, 0);
            if (i == 1)   check("sat_lt_1", 32'(bus.lt_cnt), 1);
            if (i == 254) check("sat_lt_254", 32'(bus.lt_cnt), 254);
            if (i == 255) check("sat_lt_255", 32'(bus.lt_cnt), 255);
        end
        check("sat_lt_300", 32'(bus.lt_cnt), 255);
        check("sat_run", 32'(bus.eq_run), 0);
        check("sat_out_lt", 32'(bus.out_lt), 1);

        // Relock, then clear together with a valid eq.
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        check("relock_locked", 32'(bus.locked), 1);
        check("relock_eq_cnt", 32'(bus.eq_cnt), 8);
        step(1, 0, 1, 0, 1);
        check_zero("clear");

`ifdef CMP_ONEHOT_CHECK_EN
        // Illegal 101: error, nothing counted, later samples ignored.
        step(1, 1, 0, 1, 0);
        check("ill_err", 32'(bus.err), 1);
        check("ill_gt_cnt", 32'(bus.gt_cnt), 0);
        check("ill_lt_cnt", 32'(bus.lt_cnt), 0);
        check("ill_valid", 32'(bus.out_valid), 0);
        check("ill_state", 32'(dut.state), 32'(ERROR));
        step(1, 0, 1, 0, 0);
        check("ill_ignore_eq", 32'(bus.eq_cnt), 0);
        check("ill_ignore_valid", 32'(bus.out_valid), 0);
        check("ill_sticky", 32'(bus.err), 1);
        step(0, 0, 0, 0, 1);
        check_zero("ill_clear");
        // Illegal 111 while locked: no lock_lost pulse.
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        check("ill_pre_locked", 32'(bus.locked), 1);
        step(1, 1, 1, 1, 0);
        check("ill_lk_err", 32'(bus.err), 1);
        check("ill_lk_locked", 32'(bus.locked), 0);
        check("ill_lk_pulse", 32'(bus.lock_lost), 0);
        check("ill_lk_run", 32'(bus.eq_run), 4);
`else
        // Illegal 101 resolves to gt.
        step(1, 1, 0, 1, 0);
        check("ill_gt_cnt", 32'(bus.gt_cnt), 1);
        check("ill_lt_cnt", 32'(bus.lt_cnt), 0);
        check("ill_err", 32'(bus.err), 0);
        check("ill_out_gt", 32'(bus.out_gt), 1);
        check("ill_state", 32'(dut.state), 32'(TRACK));
        // 011 resolves to eq.
        step(1, 0, 1, 1, 0);
        check("ill_eq_cnt", 32'(bus.eq_cnt), 1);
        check("ill_eq_run", 32'(bus.eq_run), 1);
        // 000 resolves to lt and breaks the run.
        step(1, 0, 0, 0, 0);
        check("ill_zero_lt", 32'(bus.lt_cnt), 1);
        check("ill_zero_run", 32'(bus.eq_run), 0);
        check("ill_zero_out_lt", 32'(bus.out_lt), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes the valid-qualified greater/equal/less flags once per cycle and registers them with 1-cycle latency.
- Keeps saturating per-class occurrence counters and tracks the run of consecutive "equal" results.
- Declares a match lock after LOCK_LEN consecutive equals; the lock feeds downstream control logic.

Parameters:
- CNT_W, 8: width of each saturating class counter.
- LOCK_LEN, 4: consecutive equal samples required to enter LOCKED; legal range is 1 to 2^RUN_W-1.
- RUN_W, 4: width of the equal-run counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear of counters, run, state and err.
- in_valid  input  1  sample qualifier for in_gt/in_eq/in_lt.
- in_gt  input  1  comparator a>b flag.
- in_eq  input  1  comparator a==b flag.
- in_lt  input  1  comparator a<b flag.
- out_valid  output  1  registered in_valid of an accepted sample.
- out_gt  output  1  registered class flag.
- out_eq  output  1  registered class flag.
- out_lt  output  1  registered class flag.
- gt_cnt  output  CNT_W  accepted gt sample count, saturating.
- eq_cnt  output  CNT_W  accepted eq sample count, saturating.
- lt_cnt  output  CNT_W  accepted lt sample count, saturating.
- eq_run  output  RUN_W  current consecutive-equal run length, saturating.
- locked  output  1  high while state is LOCKED.
- lock_lost  output  1  one-cycle pulse when LOCKED is exited on a non-equal sample.
- err  output  1  sticky illegal-flag indicator; tied 0 without the optional feature.

Behaviour:
- Reset: one clock, synchronous active-high reset, named clk and rst. When rst=1 at an edge, every output becomes 0 and the state becomes IDLE.
- Priority: rst > clear > sample. clear has the same effect as rst. A sample that arrives together with clear is discarded, and out_valid=0 on the next cycle.
- Sample class decode: exactly one flag set gives that class. Illegal combinations are handled as described under Optional Feature.
- Latency: out_* show the accepted sample one edge after it is presented. Counters, eq_run, locked and lock_lost update on that same edge.
- in_valid=0: out_valid=0 next cycle; out_gt/out_eq/out_lt hold their last values; counters, run and state hold.
- Counters: increment by 1 per accepted sample of their class and stick at all-ones, never wrapping. eq_run increments on eq and sticks at all-ones. Any accepted gt or lt sample sets eq_run to 0.
- FSM states: IDLE, TRACK, LOCKED, ERROR.
  - IDLE: no sample accepted since reset/clear. The first accepted sample moves to TRACK, or to LOCKED if it is eq and LOCK_LEN=1.
  - TRACK: on an eq sample, if the incremented run is >= LOCK_LEN, move to LOCKED (locked rises on the same edge). On a gt/lt sample, stay in TRACK.
  - LOCKED: eq samples keep the state. A gt/lt sample moves to TRACK, sets eq_run to 0 and pulses lock_lost high for exactly one cycle.
  - ERROR: reachable only with the optional feature. Sticky until rst or clear. Counters, eq_run and out_* freeze; out_valid=0; locked=0.
- No back-pressure; a sample is accepted on every valid cycle.

Optional Feature:
- Macro: CMP_ONEHOT_CHECK_EN.
- Defined: a valid sample whose flags are not exactly one-hot (000, 011, 101, 110, 111) is not counted. On the next edge the state goes to ERROR and err=1. If the block was LOCKED, lock_lost does not pulse.
- Undefined: an illegal combination is resolved by priority gt > eq > lt; 000 is treated as lt. err is tied to 0, and ERROR state logic is not synthesised.

Decomposition:
- Package cmp_pkg holds:
  - state enum {IDLE, TRACK, LOCKED, ERROR};
  - class encoding {CLS_GT, CLS_EQ, CLS_LT};
  - default constants for CNT_W, RUN_W and LOCK_LEN.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is instanced four times: three class counters and eq_run.

Test Plan:
- Default parameters (CNT_W=8, RUN_W=4, LOCK_LEN=4) for all cases.
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 for 5 cycles -> all outputs 0, state IDLE.
- Lock entry: eq, eq, eq, eq on 4 consecutive cycles -> eq_run=1,2,3,4; locked rises on the edge after the 4th sample; eq_cnt=4.
- Lock loss: while locked, apply gt -> next cycle locked=0, lock_lost=1 for one cycle only, eq_run=0, gt_cnt=1.
- Saturation: 300 consecutive lt samples -> lt_cnt stops at 255; eq_run stays 0.
- Clear priority: clear=1 together with valid eq while locked -> next cycle all counters 0, locked=0, out_valid=0.
- Illegal flags, with CMP_ONEHOT_CHECK_EN defined: apply gt=1, lt=1 valid -> err=1 next cycle, counters unchanged, further samples ignored until clear. With the macro undefined, the same stimulus -> gt_cnt increments, err=0.
